// File: rtl/fetch_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module      : fetch_ctrl_if
// Description : Handshake bundle between the fetch sequencer, instruction
//               memory and decode.
//               master : fetch side (drives requests, presents instructions)
//               slave  : memory/decode side
//               imem_req_valid/ready/addr  - fetch request channel
//               imem_rsp_valid/data        - read response channel
//               inst_valid/ready/data/pc   - instruction delivery channel
// Revision    : 1.0 - initial release
//==============================================================================
interface fetch_ctrl_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer. Owns the PC, issues fetch
//               requests, captures the response and hands the instruction to
//               decode. Handles branch redirects, halt and a sticky fault.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               pc_out            - current program counter
//               bus (master)      - imem request/response + decode handshake
//               redirect_valid/pc - taken branch/jump target
//               halt              - stop at the next instruction boundary
//               fault             - sticky error flag (cleared only by rst)
// Options     : FETCH_TIMEOUT_EN  - watchdog on WAIT/DRAIN, faults after
//                                   MAX_WAIT cycles without a response
// Revision    : 1.0 - initial release
//==============================================================================
module fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc_out,
    fetch_ctrl_if.master    bus,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            fault
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_DELIVER = 3'd3,
        S_DRAIN   = 3'd4,
        S_HALTED  = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_inst_data;
    logic [XLEN-1:0] r_inst_pc;
    logic            w_capture;
    logic            w_redir_ok;
    logic            w_redir_bad;
    logic            w_timeout;

    // A misaligned target is a fault, not a redirect; FAULT ignores both.
    assign w_redir_ok  = redirect_valid && (r_state != S_FAULT) && (redirect_pc[1:0] == 2'b00);
    assign w_redir_bad = redirect_valid && (r_state != S_FAULT) && (redirect_pc[1:0] != 2'b00);

`ifdef FETCH_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(MAX_WAIT + 1);

    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               w_in_mem;

    assign w_in_mem  = (r_state == S_WAIT) || (r_state == S_DRAIN);
    // The cycle that would bring the count to MAX_WAIT trips the fault.
    assign w_timeout = w_in_mem && !bus.imem_rsp_valid &&
                       (r_wait_cnt == c_cnt_w'(MAX_WAIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if ((w_state_nxt != r_state) &&
                     ((w_state_nxt == S_WAIT) || (w_state_nxt == S_DRAIN))) begin
            r_wait_cnt <= '0;
        end else if (w_in_mem && !bus.imem_rsp_valid) begin
            r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
        end
    end
`else
    logic w_unused_max_wait;

    assign w_unused_max_wait = (MAX_WAIT > 0);
    assign w_timeout         = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;

        case (r_state)
            S_IDLE:    w_state_nxt = halt ? S_HALTED : S_FETCH;
            S_FETCH:   if (bus.imem_req_ready) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (bus.inst_ready) begin
                    w_pc_nxt    = r_pc + c_pc_step;
                    w_state_nxt = halt ? S_HALTED : S_FETCH;
                end
            end
            S_HALTED:  if (!halt) w_state_nxt = S_FETCH;
            S_DRAIN:   if (bus.imem_rsp_valid) w_state_nxt = S_FETCH;
            S_FAULT:   w_state_nxt = S_FAULT;
            default:   w_state_nxt = S_FAULT;
        endcase

        // Redirect overrides normal flow. An accepted-but-unanswered request
        // must have its response swallowed in DRAIN before refetching.
        if (w_redir_ok) begin
            w_pc_nxt  = redirect_pc;
            w_capture = 1'b0;
            case (r_state)
                S_FETCH:   w_state_nxt = bus.imem_req_ready ? S_DRAIN : S_FETCH;
                S_WAIT:    w_state_nxt = bus.imem_rsp_valid ? S_FETCH : S_DRAIN;
                S_DELIVER: w_state_nxt = S_FETCH;
                default:   ;
            endcase
        end

        if (w_redir_bad || w_timeout) begin
            w_state_nxt = S_FAULT;
            w_pc_nxt    = r_pc;
            w_capture   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_inst_data <= '0;
            r_inst_pc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_capture) begin
                r_inst_data <= bus.imem_rsp_data;
                r_inst_pc   <= r_pc;
            end
        end
    end

    // All outputs come from registers or a decode of the state register.
    assign pc_out             = r_pc;
    assign bus.imem_req_valid = (r_state == S_FETCH);
    assign bus.imem_req_addr  = r_pc;
    assign bus.inst_valid     = (r_state == S_DELIVER);
    assign bus.inst_data      = r_inst_data;
    assign bus.inst_pc        = r_inst_pc;
    assign fault              = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives it through a fetch–wait–deliver cycle. It issues read requests to instruction memory over a valid/ready handshake and captures the response. It then presents the instruction to decode over a second valid/ready handshake. It also applies branch redirects, halt requests and a sticky fault; it sits between the PC register stage and decode.

## Interface
- XLEN, 32, data/address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- MAX_WAIT, 15, max cycles in WAIT/DRAIN before timeout fault (only with watchdog compiled in)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- pc_out  out  XLEN  current PC
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (= pc_out)
- imem_rsp_valid  in  1  read data valid
- imem_rsp_data  in  XLEN  read data
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst_data  out  XLEN  instruction word
- inst_pc  out  XLEN  address of inst_data
- redirect_valid  in  1  branch/jump taken
- redirect_pc  in  XLEN  target PC
- halt  in  1  stop fetching at next instruction boundary
- fault  out  1  sticky error flag

## Operation
- States: IDLE, FETCH, WAIT, DELIVER, DRAIN, HALTED, FAULT.
- IDLE (reset state):
  - → HALTED if halt, else → FETCH.
- FETCH: imem_req_valid=1, imem_req_addr=pc_out.
  - On req handshake → WAIT.
- WAIT: on imem_rsp_valid, register imem_rsp_data→inst_data and pc_out→inst_pc, then → DELIVER.
- DELIVER: inst_valid=1, inst_data/inst_pc held stable.
  - On inst handshake: pc_out ← pc_out+4 (mod 2^XLEN, wraps 32'hFFFF_FFFC→0).
  - Then → HALTED if halt, else → FETCH.
- HALTED: no requests; → FETCH when halt=0.
- DRAIN: discard one outstanding response.
  - On imem_rsp_valid → FETCH; data is not captured.
- FAULT: all valids 0, fault=1; exit only by rst.
- Redirect (redirect_valid=1, any state except FAULT):
  - redirect_pc[1:0]≠0 → FAULT, pc_out unchanged.
  - Otherwise pc_out ← redirect_pc, with state changes:
    - FETCH without handshake: stay FETCH; address changes next cycle (memory tolerates unaccepted-address change).
    - FETCH with handshake, or WAIT without rsp: → DRAIN.
    - WAIT with rsp same cycle: response dropped → FETCH.
    - DELIVER: inst_valid drops next cycle → FETCH. A same-cycle inst handshake counts as delivered, and the redirect overrides the +4.
    - HALTED/IDLE/DRAIN: only pc_out updates; state transition unchanged.
- Priority: rst > fault detection > redirect > halt > normal flow.
- imem_rsp_valid is ignored outside WAIT/DRAIN.

## Timing
- Reset values:
  - pc_out=RESET_PC, imem_req_addr=RESET_PC.
  - imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, fault=0, state=IDLE.
- After rst deasserts: IDLE one cycle; imem_req_valid=1 on the 2nd edge.
- imem_req_valid, once high, stays high until handshake (except redirect address update).
- Minimum throughput: 3 cycles per instruction (FETCH accept, WAIT rsp, DELIVER accept) with zero-wait memory and ready decode.
- inst_valid rises the cycle after imem_rsp_valid in WAIT.
- Outputs are registered or decoded from state only; no combinational path from any input to any output.
- rst mid-operation (any state) returns to reset values immediately; in-flight responses after reset are ignored (IDLE/FETCH ignore rsp).

## Configuration
- FETCH_TIMEOUT_EN defined:
  - Counter (width $clog2(MAX_WAIT+1)) clears on entry to WAIT/DRAIN and increments each cycle there without imem_rsp_valid.
  - Reaching MAX_WAIT → FAULT.
- Undefined: no counter; WAIT/DRAIN wait indefinitely; fault only from misaligned redirect.

## Test plan
- Reset, RESET_PC=0, zero-wait memory, inst_ready=1 → inst_pc sequence 0,4,8 with inst_valid every 3rd cycle; pc_out=12 after third delivery.
- Redirect to 0x100 one cycle after FETCH handshake, memory answers 2 cycles later → response dropped (no inst_valid), next imem_req_addr=0x100.
- Redirect to 0x102 in DELIVER → fault=1 next cycle, inst_valid=0, no further requests until rst.
- halt=1 during DELIVER with inst_ready=1 → HALTED, imem_req_valid=0; halt=0 → request at pc+4 next cycle.
- RESET_PC=32'hFFFF_FFFC, one delivery → pc_out wraps to 0.
- FETCH_TIMEOUT_EN, MAX_WAIT=15, memory never responds → fault=1 after 15 cycles in WAIT; without macro fault stays 0 after 100 cycles.
